// File: rtl/fftreorder_if.sv
// Sample stream bundle for the FFT output reorder buffer.
// The master side drives the input stream; the slave side (the reorder buffer) returns the reordered stream.
interface fftreorder_if #(
    parameter int WIDTH = 38
);
    logic             i_ce;
    logic             i_sync;
    logic [WIDTH-1:0] i_sample;
    logic             i_brev;
    logic [WIDTH-1:0] o_sample;
    logic             o_sync;
    logic             o_frame_err;

    modport master (
        output i_ce, i_sync, i_sample, i_brev,
        input  o_sample, o_sync, o_frame_err
    );

    modport slave (
        input  i_ce, i_sync, i_sample, i_brev,
        output o_sample, o_sync, o_frame_err
    );
endinterface

// File: rtl/fftreorder.sv
// Ping-pong reorder buffer for the FFT output: each frame is emitted either in
// bit-reversed-address order (natural order out) or in input order, with sync alignment checking.
//
// state   | meaning
// S_IDLE  | not armed; samples are ignored until the first i_ce & i_sync
// S_RUN   | armed; frames free-run on the write index wrap
module fftreorder #(
    parameter int LGSIZE = 4,
    parameter int WIDTH  = 38
) (
    input  logic        i_clk,
    input  logic        i_reset,
    fftreorder_if.slave bus
);
    localparam int N = 1 << LGSIZE;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t state, state_nxt;

    logic [LGSIZE-1:0] wr_idx;
    logic              wr_bank;
    logic [1:0]        bank_full;
    logic [1:0]        bank_brev;
    logic              rd_valid;
    logic              rd_first;
    logic [WIDTH-1:0]  rd_data;
    logic [WIDTH-1:0]  mem [0:2*N-1];

    logic              armed;
    logic              accept;
    logic              misalign;
    logic              rd_bank;
    logic              rd_go;
    logic [LGSIZE-1:0] rd_idx;
    logic [LGSIZE:0]   wr_addr;

    function automatic logic [LGSIZE-1:0] bitrev(input logic [LGSIZE-1:0] v);
        logic [LGSIZE-1:0] r;
        r = '0;
        for (int b = 0; b < LGSIZE; b++) begin
            r[b] = v[LGSIZE-1-b];
        end
        return r;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.i_ce && bus.i_sync) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign armed    = (state == S_RUN);
    assign accept   = bus.i_ce && (armed || bus.i_sync);
    assign misalign = bus.i_ce && armed && bus.i_sync && (wr_idx != '0);
    assign wr_addr  = misalign ? '0 : {wr_bank, wr_idx};

    // The bank not being written is the one read out, slot by slot in step with wr_idx.
    assign rd_bank  = ~wr_bank;
    assign rd_go    = bus.i_ce && armed && !misalign && bank_full[rd_bank];
    assign rd_idx   = bank_brev[rd_bank] ? bitrev(wr_idx) : wr_idx;

    always_ff @(posedge i_clk) begin
        if (accept) begin
            mem[wr_addr] <= bus.i_sample;
        end
    end

    always_ff @(posedge i_clk) begin
        if (rd_go) begin
            rd_data <= mem[{rd_bank, rd_idx}];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_idx          <= '0;
            wr_bank         <= 1'b0;
            bank_full       <= '0;
            bank_brev       <= '0;
            rd_valid        <= 1'b0;
            rd_first        <= 1'b0;
            bus.o_sample    <= '0;
            bus.o_sync      <= 1'b0;
            bus.o_frame_err <= 1'b0;
        end else if (bus.i_ce) begin
            bus.o_sample <= rd_valid ? rd_data : '0;
            bus.o_sync   <= rd_valid && rd_first;
            rd_valid     <= rd_go;
            rd_first     <= rd_go && (wr_idx == '0);

            if (misalign) begin
                // Abandon everything buffered and restart as index 0 of bank 0.
                bus.o_frame_err <= 1'b1;
                bus.o_sample    <= '0;
                bus.o_sync      <= 1'b0;
                rd_valid        <= 1'b0;
                bank_full       <= '0;
                bank_brev[0]    <= bus.i_brev;
                wr_bank         <= 1'b0;
                wr_idx          <= {{(LGSIZE-1){1'b0}}, 1'b1};
            end else if (accept) begin
                if (wr_idx == '0) begin
                    bank_brev[wr_bank] <= bus.i_brev;
                end
                if (rd_go && (&wr_idx)) begin
                    bank_full[rd_bank] <= 1'b0;
                end
                if (&wr_idx) begin
                    bank_full[wr_bank] <= 1'b1;
                    wr_bank            <= ~wr_bank;
                end
                wr_idx <= wr_idx + {{(LGSIZE-1){1'b0}}, 1'b1};
            end
        end
    end
endmodule

// File: tb/tb_fftreorder.sv
// Scoreboard bench for fftreorder: the driver queues expected output slots keyed by
// ce-edge number, and the monitor checks every edge (slot data, idle zeros, holds, error flag).
module tb_fftreorder;
    localparam int LGSIZE = 4;
    localparam int N      = 16;
    localparam int WIDTH  = 38;

    typedef struct {
        int               due;
        logic [WIDTH-1:0] data;
        bit               sync;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_reset;

    fftreorder_if #(.WIDTH(WIDTH)) bus ();

    fftreorder #(.LGSIZE(LGSIZE), .WIDTH(WIDTH)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    exp_t q[$];
    int   n_vec    = 0;
    int   n_bad    = 0;
    int   ce_edges = 0;
    int   err_edge = 0;
    bit   last_ce  = 1'b0;
    bit   last_rst = 1'b0;
    int   brev_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    always @(posedge i_clk) begin
        last_ce  <= bus.i_ce && !i_reset;
        last_rst <= i_reset;
        if (bus.i_ce && !i_reset) ce_edges <= ce_edges + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (ce edge %0d, t=%0t)", name, act, exp, ce_edges, $time);
        end
    endtask

    // Monitor
    initial begin
        logic [WIDTH-1:0] hd;
        bit               hs;
        bit               he;
        bit               started;
        int               k;
        hd = '0; hs = 1'b0; he = 1'b0; started = 1'b0;
        forever begin
            @(negedge i_clk);
            if (last_rst) begin
                started = 1'b1;
                hd = '0; hs = 1'b0; he = 1'b0;
                chk("rst_sample", 64'(bus.o_sample), 64'(0));
                chk("rst_sync", 64'(bus.o_sync), 64'(0));
                chk("rst_err", 64'(bus.o_frame_err), 64'(0));
            end else if (started && last_ce) begin
                k = ce_edges;
                while (q.size() > 0 && q[0].due < k) begin
                    chk("missed_slot", 64'(q[0].due), 64'(k));
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].due == k) begin
                    hd = q[0].data;
                    hs = q[0].sync;
                    void'(q.pop_front());
                end else begin
                    hd = '0;
                    hs = 1'b0;
                end
                he = (err_edge != 0) && (k >= err_edge);
                chk("sample", 64'(bus.o_sample), 64'(hd));
                chk("sync", 64'(bus.o_sync), 64'(hs));
                chk("frame_err", 64'(bus.o_frame_err), 64'(he));
            end else if (started) begin
                chk("hold_sample", 64'(bus.o_sample), 64'(hd));
                chk("hold_sync", 64'(bus.o_sync), 64'(hs));
                chk("hold_err", 64'(bus.o_frame_err), 64'(he));
            end
        end
    end

    task automatic cyc(input bit ce, input bit sync, input logic [WIDTH-1:0] s, input bit b);
        bus.i_ce     = ce;
        bus.i_sync   = sync;
        bus.i_sample = s;
        bus.i_brev   = b;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        i_reset = 1'b1;
        while (q.size() > 0 && q[$].due > ce_edges) void'(q.pop_back());
        repeat (n) cyc(1'b0, 1'b0, '0, 1'b0);
        i_reset  = 1'b0;
        err_edge = 0;
    endtask

    // One full frame; flip inverts i_brev after index 0, mis marks a misaligned sync at index 0.
    task automatic frame(input int base, input bit brev, input bit sync0, input bit flip,
                         input bit gaps, input bit mis);
        int   e0;
        exp_t x;
        e0 = 0;
        for (int j = 0; j < N; j++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 1)) cyc(1'b0, 1'($urandom_range(0, 1)), {WIDTH{1'b1}}, ~brev);
            end
            if (j == 0) begin
                e0 = ce_edges + 1;
                if (mis) begin
                    while (q.size() > 0 && q[$].due >= e0) void'(q.pop_back());
                    err_edge = e0;
                end
            end
            cyc(1'b1, (j == 0) && sync0, WIDTH'(base + j), (j == 0) ? brev : (brev ^ flip));
        end
        for (int j = 0; j < N; j++) begin
            x.due  = e0 + N + j + 1;
            x.data = WIDTH'(base + (brev ? brev_tab[j] : j));
            x.sync = (j == 0);
            q.push_back(x);
        end
    endtask

    task automatic partial(input int base, input int n);
        for (int j = 0; j < n; j++) cyc(1'b1, 1'b0, WIDTH'(base + j), 1'b1);
    endtask

    // Enough ce edges to drain the previous frame without completing another readout.
    task automatic flush();
        for (int j = 0; j < N + 1; j++) cyc(1'b1, 1'b0, WIDTH'(32'hF00 + j), 1'b0);
    endtask

    initial begin
        bus.i_ce = 1'b0; bus.i_sync = 1'b0; bus.i_sample = '0; bus.i_brev = 1'b0;
        i_reset = 1'b1;
        do_reset(2);

        // Unsynced samples are ignored
        repeat (5) cyc(1'b1, 1'b0, WIDTH'(32'hDEAD), 1'b1);

        // Bit-reversed frames, then pass-through, then mid-frame mode changes
        frame(32'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        frame(32'h010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(32'h020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(32'h030, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        frame(32'h040, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        flush();

        // Gapped clock enable
        do_reset(2);
        frame(32'h100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        frame(32'h110, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        frame(32'h120, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        flush();

        // Misaligned sync at wr_idx 7
        do_reset(1);
        frame(32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        frame(32'h210, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        partial(32'h220, 7);
        frame(32'h230, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        frame(32'h240, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a readout
        partial(32'h250, 5);
        do_reset(1);
        repeat (3) cyc(1'b1, 1'b0, WIDTH'(32'h77), 1'b1);
        frame(32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        flush();

        repeat (3) cyc(1'b0, 1'b0, '0, 1'b0);
        @(negedge i_clk);
        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
